// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - shared opcodes, FSM states, ALU codes and control vector for the multicycle datapath
package ctrl_pkg;

    localparam logic [3:0] OP_RTYPE = 4'b0000;
    localparam logic [3:0] OP_ADDI  = 4'b0001;
    localparam logic [3:0] OP_LW    = 4'b0010;
    localparam logic [3:0] OP_SW    = 4'b0011;
    localparam logic [3:0] OP_BEQ   = 4'b0100;
    localparam logic [3:0] OP_J     = 4'b0101;
    localparam logic [3:0] OP_HALT  = 4'b1111;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    typedef struct packed {
        logic       ir_write;
        logic       pc_write;
        logic       beq;
        logic       jump;
        logic       reg_dst;
        logic       alu_src;
        logic       mem_to_reg;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic [1:0] alu_op;
        logic       instr_done;
        logic       illegal;
        logic       halted;
    } ctrl_t;

    function automatic logic is_legal(input logic [3:0] op);
        case (op)
            OP_RTYPE, OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_J, OP_HALT: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// rtl/ctrl_decode.sv - combinational control vector for the current state and latched opcode
module ctrl_decode
    import ctrl_pkg::*;
(
    input  state_t      state,
    input  logic [3:0]  op_q,
    input  logic [3:0]  opcode,
    input  logic        zero,
    input  logic        mem_ready,
    input  logic        timeout,
    output ctrl_t       ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.ir_write = 1'b1;
                ctrl.pc_write = 1'b1;
            end
            S_DECODE: begin
                // op_q is loaded at the end of this cycle, so judge the live opcode here
                if (!is_legal(opcode)) begin
                    ctrl.illegal    = 1'b1;
                    ctrl.instr_done = 1'b1;
                end
            end
            S_EXEC: begin
                case (op_q)
                    OP_RTYPE: ctrl.alu_op = ALU_FUNCT;
                    OP_ADDI, OP_LW, OP_SW: begin
                        ctrl.alu_op  = ALU_ADD;
                        ctrl.alu_src = 1'b1;
                    end
                    OP_BEQ: begin
                        ctrl.alu_op     = ALU_SUB;
                        ctrl.beq        = 1'b1;
                        ctrl.pc_write   = zero;
                        ctrl.instr_done = 1'b1;
                    end
                    OP_J: begin
                        ctrl.jump       = 1'b1;
                        ctrl.pc_write   = 1'b1;
                        ctrl.instr_done = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_MEM: begin
                ctrl.alu_src = 1'b1;
                ctrl.alu_op  = ALU_ADD;
                if (timeout) begin
                    ctrl.illegal    = 1'b1;
                    ctrl.instr_done = 1'b1;
                end else begin
                    ctrl.mem_read   = (op_q == OP_LW);
                    ctrl.mem_write  = (op_q == OP_SW);
                    ctrl.instr_done = mem_ready && (op_q == OP_SW);
                end
            end
            S_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.reg_dst    = (op_q == OP_RTYPE);
                ctrl.mem_to_reg = (op_q == OP_LW);
                ctrl.instr_done = 1'b1;
            end
            S_HALT: ctrl.halted = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multicycle sequencer: state register, latched opcode and memory wait counter
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       ir_write,
    output logic       pc_write,
    output logic       beq,
    output logic       jump,
    output logic       reg_dst,
    output logic       alu_src,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       mem_read,
    output logic       mem_write,
    output logic [1:0] alu_op,
    output logic       instr_done,
    output logic       illegal,
    output logic       halted,
    output logic [2:0] state
);

    localparam int CW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] WAIT_MAX = CW'(MEM_TIMEOUT);

    state_t        state_q;
    state_t        state_d;
    logic [3:0]    op_q;
    logic [CW-1:0] wait_q;
    logic          timeout;
    ctrl_t         ctrl;

    assign timeout = (MEM_TIMEOUT != 0) && (state_q == S_MEM) && (wait_q == WAIT_MAX);

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                if (opcode == OP_HALT)
                    state_d = S_HALT;
                else if (!is_legal(opcode))
                    state_d = S_FETCH;
                else
                    state_d = S_EXEC;
            end
            S_EXEC: begin
                case (op_q)
                    OP_RTYPE, OP_ADDI: state_d = S_WB;
                    OP_LW, OP_SW:      state_d = S_MEM;
                    default:           state_d = S_FETCH;
                endcase
            end
            S_MEM: begin
                if (timeout)
                    state_d = S_FETCH;
                else if (mem_ready)
                    state_d = (op_q == OP_LW) ? S_WB : S_FETCH;
                else
                    state_d = S_MEM;
            end
            S_WB:     state_d = S_FETCH;
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
            op_q    <= 4'd0;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_DECODE)
                op_q <= opcode;
            // counts stalled MEM cycles; every MEM entry comes through EXEC, which clears it
            if (state_q != S_MEM)
                wait_q <= '0;
            else if (!mem_ready && wait_q != WAIT_MAX)
                wait_q <= wait_q + CW'(1);
        end
    end

    ctrl_decode u_decode (
        .state     (state_q),
        .op_q      (op_q),
        .opcode    (opcode),
        .zero      (zero),
        .mem_ready (mem_ready),
        .timeout   (timeout),
        .ctrl      (ctrl)
    );

    // reset overrides the decode so an abandoned instruction issues nothing
    assign ir_write   = !rst && ctrl.ir_write;
    assign pc_write   = !rst && ctrl.pc_write;
    assign beq        = !rst && ctrl.beq;
    assign jump       = !rst && ctrl.jump;
    assign reg_dst    = !rst && ctrl.reg_dst;
    assign alu_src    = !rst && ctrl.alu_src;
    assign mem_to_reg = !rst && ctrl.mem_to_reg;
    assign reg_write  = !rst && ctrl.reg_write;
    assign mem_read   = !rst && ctrl.mem_read;
    assign mem_write  = !rst && ctrl.mem_write;
    assign alu_op     = rst ? 2'b00 : ctrl.alu_op;
    assign instr_done = !rst && ctrl.instr_done;
    assign illegal    = !rst && ctrl.illegal;
    assign halted     = !rst && ctrl.halted;
    assign state      = rst ? 3'd0 : 3'(state_q);

endmodule
